// File: rtl/wb_debug_bridge.sv
// Byte-stream command bridge acting as a Wishbone classic-cycle initiator.
// Frames: PING, WRITE(adr,data), READ(adr); one status byte (+ read data) per frame.
module wb_debug_bridge #(
    parameter int BUS_TIMEOUT   = 255,
    parameter int MAX_RETRY     = 3,
    parameter int FRAME_TIMEOUT = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        CYC,
    output logic        STB,
    output logic        WE,
    output logic [31:0] ADR,
    output logic [31:0] DAT_O,
    input  logic [31:0] DAT_I,
    output logic [2:0]  CTI_O,
    input  logic        ACK,
    input  logic        ERR,
    input  logic        RTY
);
    localparam int BW = $clog2(BUS_TIMEOUT + 1);
    localparam int FW = $clog2(FRAME_TIMEOUT + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_GAP, S_RESP} state_t;

    state_t         state, state_next;
    logic [1:0]     byte_cnt;
    logic           op_write;
    logic [31:0]    adr_q, dat_q;
    logic [BW-1:0]  bus_cnt;
    logic [FW-1:0]  frame_cnt;
    logic [RW-1:0]  retry_cnt;
    logic [39:0]    resp_sr;
    logic [2:0]     resp_cnt;
    logic           tx_fire, bus_expired, frame_expired, retry_done, bus_term;

    assign tx_fire       = tx_valid & tx_ready;
    assign bus_expired   = (bus_cnt == '0);
    assign frame_expired = (frame_cnt == '0);
    assign retry_done    = (retry_cnt == RW'(MAX_RETRY));
    assign bus_term      = ACK | ERR | RTY;

    assign CYC      = (state == S_BUS);
    assign STB      = (state == S_BUS);
    assign WE       = op_write & (state == S_BUS);
    assign ADR      = adr_q;
    assign DAT_O    = dat_q;
    assign CTI_O    = 3'b000;
    assign tx_valid = (state == S_RESP);
    assign tx_data  = resp_sr[7:0];
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == 8'h01 || rx_data == 8'h02) state_next = S_ADDR;
                    else                                      state_next = S_RESP;
                end
            end
            S_ADDR: begin
                if (rx_valid) begin
                    if (byte_cnt == 2'd3) state_next = op_write ? S_DATA : S_BUS;
                end else if (frame_expired) begin
                    state_next = S_IDLE;
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    if (byte_cnt == 2'd3) state_next = S_BUS;
                end else if (frame_expired) begin
                    state_next = S_IDLE;
                end
            end
            S_BUS: begin
                if (bus_term) begin
                    if (!ERR && RTY && !retry_done) state_next = S_GAP;
                    else                            state_next = S_RESP;
                end else if (bus_expired) begin
                    state_next = S_RESP;
                end
            end
            S_GAP:  state_next = S_BUS;
            S_RESP: if (tx_fire && resp_cnt == 3'd1) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt  <= '0;
            op_write  <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            bus_cnt   <= '0;
            frame_cnt <= '0;
            retry_cnt <= '0;
            resp_sr   <= '0;
            resp_cnt  <= '0;
        end else begin
            // Timer reloads outside BUS so every attempt (incl. after a retry gap) starts fresh.
            if (state != S_BUS) bus_cnt <= BW'(BUS_TIMEOUT - 1);
            unique case (state)
                S_IDLE: begin
                    if (rx_valid) begin
                        op_write  <= (rx_data == 8'h01);
                        byte_cnt  <= '0;
                        retry_cnt <= '0;
                        frame_cnt <= FW'(FRAME_TIMEOUT - 1);
                        resp_cnt  <= 3'd1;
                        resp_sr   <= {32'h0, (rx_data == 8'h00) ? 8'h5A : 8'hE0};
                    end
                end
                S_ADDR, S_DATA: begin
                    if (rx_valid) begin
                        if (state == S_ADDR) adr_q <= {rx_data, adr_q[31:8]};
                        else                 dat_q <= {rx_data, dat_q[31:8]};
                        byte_cnt  <= byte_cnt + 2'd1;
                        frame_cnt <= FW'(FRAME_TIMEOUT - 1);
                    end else if (!frame_expired) begin
                        frame_cnt <= frame_cnt - FW'(1);
                    end
                end
                S_BUS: begin
                    if (ERR) begin
                        resp_sr  <= {32'h0, 8'hE1};
                        resp_cnt <= 3'd1;
                    end else if (RTY) begin
                        if (retry_done) begin
                            resp_sr  <= {32'h0, 8'hE2};
                            resp_cnt <= 3'd1;
                        end else begin
                            retry_cnt <= retry_cnt + RW'(1);
                        end
                    end else if (ACK) begin
                        resp_sr  <= {DAT_I, 8'hA5};
                        resp_cnt <= op_write ? 3'd1 : 3'd5;
                    end else if (bus_expired) begin
                        resp_sr  <= {32'h0, 8'hE3};
                        resp_cnt <= 3'd1;
                    end else begin
                        bus_cnt <= bus_cnt - BW'(1);
                    end
                end
                S_RESP: begin
                    if (tx_fire) begin
                        resp_sr  <= {8'h00, resp_sr[39:8]};
                        resp_cnt <= resp_cnt - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_debug_bridge.sv
// Scoreboard bench for wb_debug_bridge: expected reply bytes are queued when a
// frame is sent and popped as the bridge hands bytes to the transmitter.
module tb_wb_debug_bridge;
    localparam int FT = 200;
    localparam int M_ACK = 0, M_RTY = 1, M_RTY_ACK = 2, M_NONE = 3, M_ERRACK = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy, CYC, STB, WE, ACK, ERR, RTY;
    logic [31:0] ADR, DAT_O, DAT_I;
    logic [2:0]  CTI_O;

    wb_debug_bridge #(.BUS_TIMEOUT(255), .MAX_RETRY(3), .FRAME_TIMEOUT(FT)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
        .CYC(CYC), .STB(STB), .WE(WE), .ADR(ADR), .DAT_O(DAT_O), .DAT_I(DAT_I),
        .CTI_O(CTI_O), .ACK(ACK), .ERR(ERR), .RTY(RTY)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Slave model and bus observer
    int mode = M_ACK, ws = 0, ack_at = 0;
    int attempts = 0, stb_run = 0, last_run = 0, low_run = 0;
    logic [31:0] exp_adr = 0, exp_dat = 0, rd_data = 0;
    logic exp_we = 0, chk_dat = 0, prev_stb = 0;

    initial begin
        ACK = 0; ERR = 0; RTY = 0; DAT_I = 0;
        forever begin
            @(posedge clk); #1;
            ACK = 0; ERR = 0; RTY = 0;
            if (STB) begin
                if (!prev_stb) begin
                    attempts++;
                    if (attempts > 1) chk("retry_gap", low_run, 1);
                    chk("adr", ADR, exp_adr);
                    chk("we", WE, exp_we);
                    if (chk_dat) chk("dat_o", DAT_O, exp_dat);
                    stb_run = 0;
                end
                stb_run++;
                low_run = 0;
                case (mode)
                    M_ACK:     if (stb_run == ws + 1) begin ACK = 1; DAT_I = rd_data; end
                    M_RTY:     RTY = 1;
                    M_RTY_ACK: if (attempts >= ack_at) begin ACK = 1; DAT_I = rd_data; end else RTY = 1;
                    M_ERRACK:  begin ERR = 1; ACK = 1; end
                    default:   ;
                endcase
            end else begin
                if (prev_stb) last_run = stb_run;
                low_run++;
            end
            prev_stb = STB;
        end
    end

    // Transmitter side: random or always-ready acceptance
    logic rand_rdy = 0;
    initial begin
        tx_ready = 1;
        forever begin
            @(posedge clk); #1;
            tx_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    logic       held = 0;
    logic [7:0] held_data = 0;
    initial forever begin
        @(negedge clk);
        if (!rst && tx_valid) begin
            if (held) chk("tx_hold", {24'h0, tx_data}, {24'h0, held_data});
            if (tx_ready) begin
                held = 0;
                if (exp_q.size() == 0) chk("tx_extra", {24'h0, tx_data}, 32'h100);
                else                   chk("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
            end else begin
                held = 1;
                held_data = tx_data;
            end
        end else begin
            held = 0;
        end
    end

    task automatic send(input logic [7:0] b);
        rx_data = b; rx_valid = 1;
        @(posedge clk); #1;
        rx_valid = 0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send(8'(w >> (8 * i)));
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_busy", busy, 0);
        chk("idle_queue", exp_q.size(), 0);
    endtask

    task automatic prep(input int m, input int w, input logic [31:0] a, input logic we, input logic [31:0] d);
        mode = m; ws = w; exp_adr = a; exp_we = we; exp_dat = d; chk_dat = we; attempts = 0;
    endtask

    task automatic push_read_reply(input logic [31:0] d);
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 4; i++) exp_q.push_back(8'(d >> (8 * i)));
    endtask

    initial begin
        rst = 1; rx_valid = 0; rx_data = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cyc", CYC, 0);   chk("rst_stb", STB, 0);   chk("rst_we", WE, 0);
        chk("rst_adr", ADR, 0);   chk("rst_dat", DAT_O, 0); chk("rst_cti", CTI_O, 0);
        chk("rst_txv", tx_valid, 0); chk("rst_txd", tx_data, 0); chk("rst_busy", busy, 0);
        rst = 0;
        @(posedge clk); #1;

        // WRITE with two wait states
        prep(M_ACK, 2, 32'h10, 1, 32'hDEADBEEF);
        exp_q.push_back(8'hA5);
        send(8'h01); send_word(32'h10); send_word(32'hDEADBEEF);
        chk("wr_cyc_start", CYC, 1);
        chk("wr_busy", busy, 1);
        wait_idle(100);
        chk("wr_attempts", attempts, 1);
        chk("wr_stb_len", last_run, 3);

        // READ with random tx_ready
        prep(M_ACK, 1, 32'h10, 0, 0);
        rd_data = 32'h12345678; rand_rdy = 1;
        push_read_reply(rd_data);
        send(8'h02); send_word(32'h10);
        wait_idle(300);
        rand_rdy = 0;
        chk("rd_attempts", attempts, 1);

        // RTY on every attempt
        prep(M_RTY, 0, 32'h1000, 1, 32'h01020304);
        exp_q.push_back(8'hE2);
        send(8'h01); send_word(32'h1000); send_word(32'h01020304);
        wait_idle(100);
        chk("rty_attempts", attempts, 4);

        // RTY twice then ACK
        prep(M_RTY_ACK, 0, 32'h1004, 1, 32'hA0B0C0D0);
        ack_at = 3;
        exp_q.push_back(8'hA5);
        send(8'h01); send_word(32'h1004); send_word(32'hA0B0C0D0);
        wait_idle(100);
        chk("rty_ack_attempts", attempts, 3);

        // Silent slave: bus timeout
        prep(M_NONE, 0, 32'h0FFC, 0, 0);
        exp_q.push_back(8'hE3);
        send(8'h02); send_word(32'h0FFC);
        wait_idle(400);
        chk("tmo_stb_len", last_run, 255);
        chk("tmo_attempts", attempts, 1);

        // ERR and ACK together: ERR wins
        prep(M_ERRACK, 0, 32'h1100, 0, 0);
        exp_q.push_back(8'hE1);
        send(8'h02); send_word(32'h1100);
        wait_idle(100);

        // Unknown opcode
        prep(M_ACK, 0, 0, 0, 0);
        exp_q.push_back(8'hE0);
        send(8'h7F);
        chk("bad_txv", tx_valid, 1);
        wait_idle(50);
        chk("bad_no_cyc", attempts, 0);

        // PING
        exp_q.push_back(8'h5A);
        send(8'h00);
        chk("ping_txv", tx_valid, 1);
        wait_idle(50);
        chk("ping_no_cyc", attempts, 0);

        // Truncated WRITE discarded after the frame timeout, then PING
        send(8'h01); send(8'h10); send(8'h00);
        repeat (FT - 1) @(posedge clk);
        #1;
        chk("frame_busy_before", busy, 1);
        @(posedge clk); #1;
        chk("frame_busy_after", busy, 0);
        exp_q.push_back(8'h5A);
        send(8'h00);
        wait_idle(50);
        chk("frame_no_cyc", attempts, 0);

        // Bytes during BUS are dropped
        prep(M_ACK, 6, 32'h1008, 0, 0);
        rd_data = 32'hCAFEF00D;
        push_read_reply(rd_data);
        send(8'h02); send_word(32'h1008);
        send(8'h00); send(8'h00);
        wait_idle(100);
        chk("drop_attempts", attempts, 1);

        // Reset in the middle of a bus cycle
        prep(M_NONE, 0, 32'h20, 0, 0);
        send(8'h02); send_word(32'h20);
        repeat (10) @(posedge clk);
        #1;
        chk("pre_rst_cyc", CYC, 1);
        rst = 1;
        @(posedge clk); #1;
        chk("mid_rst_cyc", CYC, 0);  chk("mid_rst_stb", STB, 0);
        chk("mid_rst_txv", tx_valid, 0); chk("mid_rst_busy", busy, 0);
        chk("mid_rst_adr", ADR, 0);  chk("mid_rst_we", WE, 0); chk("mid_rst_txd", tx_data, 0);
        rst = 0;
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_txv", tx_valid, 0);

        // Normal READ after reset
        prep(M_ACK, 1, 32'h24, 0, 0);
        rd_data = 32'h89ABCDEF;
        push_read_reply(rd_data);
        send(8'h02); send_word(32'h24);
        wait_idle(100);
        chk("post_rst_attempts", attempts, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1, "watchdog");
    end
endmodule
